kfps2kb_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte (for example LED set 8'hED or reset 8'hFF) to the keyboard over the same two open-drain lines that the keyboard receiver listens on. It performs the request-to-send sequence, shifts out 8 data bits, odd parity and stop, then checks the device ACK. It raises busy so the system can gate or ignore the receiver during transmission.

---
 rtl/kfps2kb_pkg.sv | 20 ++
 rtl/kfps2kb_host_tx_if.sv | 19 +
 rtl/kfps2kb_line_sync.sv | 30 +++
 rtl/kfps2kb_host_tx.sv | 160 ++++++++++++++++
 tb/tb_kfps2kb_host_tx.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/kfps2kb_pkg.sv
// rtl/kfps2kb_pkg.sv - shared types and helpers for the PS/2 keyboard host blocks
package kfps2kb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQUEST,
    SHIFT,
    ACK,
    RELEASE
  } state_e;

  localparam int FRAME_BITS = 10;
  localparam int CNT_W      = 24;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/kfps2kb_host_tx_if.sv
// rtl/kfps2kb_host_tx_if.sv - command handshake and status bundle of the PS/2 host transmitter
interface kfps2kb_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/kfps2kb_line_sync.sv
// rtl/kfps2kb_line_sync.sv - 2-FF synchronizer and falling-edge detector for one PS/2 line
module kfps2kb_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic line_in,
  output logic sync,
  output logic fe
);
  logic [1:0] sync_q, sync_d;
  logic       prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], line_in};
    prev_d = sync_q[1];
  end

  // Lines idle high (pulled up), so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync = sync_q[1];
  assign fe   = prev_q & ~sync_q[1];
endmodule

// File: rtl/kfps2kb_host_tx.sv
// rtl/kfps2kb_host_tx.sv - PS/2 host-to-device command transmitter with ACK check and timeouts
module kfps2kb_host_tx
  import kfps2kb_pkg::*;
#(
  parameter logic [CNT_W-1:0] inhibit_time = 24'd5000,
  parameter logic [CNT_W-1:0] request_time = 24'd750000,
  parameter logic [CNT_W-1:0] over_time    = 24'd100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             device_clock,
  input  logic             device_data,
  output logic             clock_drive_low,
  output logic             data_drive_low,
  kfps2kb_host_tx_if.slave tx
);
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_sat;
  logic [CNT_W:0]        cnt_next;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic nack_q, nack_d, clk_low_q, clk_low_d, dat_low_q, dat_low_d;
  logic ready_q, ready_d, busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic timeout, clk_sync, clk_fe, dat_sync, dat_fe_unused;

  kfps2kb_line_sync u_clk_sync (
    .clock(clock), .reset(reset), .line_in(device_clock), .sync(clk_sync), .fe(clk_fe)
  );
  kfps2kb_line_sync u_dat_sync (
    .clock(clock), .reset(reset), .line_in(device_data), .sync(dat_sync), .fe(dat_fe_unused)
  );

  // cnt_next is the value the counter will hold next cycle, widened so limits compare cleanly.
  assign cnt_sat  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign cnt_next = {1'b0, cnt_q} + (CNT_W+1)'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_sat;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    nack_d    = nack_q;
    clk_low_d = 1'b0;
    dat_low_d = dat_low_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        dat_low_d = 1'b0;
        if (tx.tx_valid && ready_q) begin
          frame_d   = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
          state_d   = INHIBIT;
          clk_low_d = 1'b1;
          dat_low_d = (inhibit_time <= CNT_W'(1));
        end
      end
      INHIBIT: begin
        if (cnt_next >= {1'b0, inhibit_time}) begin
          state_d   = REQUEST;
          cnt_d     = '0;
          dat_low_d = 1'b1;
        end else begin
          clk_low_d = 1'b1;
          dat_low_d = (cnt_next + (CNT_W+1)'(1) >= {1'b0, inhibit_time});
        end
      end
      REQUEST: begin
        dat_low_d = 1'b1;
        if (clk_fe) begin
          state_d   = SHIFT;
          cnt_d     = '0;
          dat_low_d = ~frame_q[0];
          bit_cnt_d = 4'd1;
        end else if (cnt_next >= {1'b0, request_time}) begin
          timeout = 1'b1;
        end
      end
      SHIFT: begin
        if (clk_fe) begin
          cnt_d     = '0;
          dat_low_d = ~frame_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) state_d = ACK;
        end else if (cnt_next >= {1'b0, over_time}) begin
          timeout = 1'b1;
        end
      end
      ACK: begin
        dat_low_d = 1'b0;
        if (clk_fe) begin
          nack_d  = dat_sync;
          state_d = RELEASE;
          cnt_d   = '0;
        end else if (cnt_next >= {1'b0, over_time}) begin
          timeout = 1'b1;
        end
      end
      RELEASE: begin
        dat_low_d = 1'b0;
        if (clk_sync && dat_sync) begin
          done_d  = 1'b1;
          error_d = nack_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_next >= {1'b0, over_time}) begin
          timeout = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d   = IDLE;
      cnt_d     = '0;
      clk_low_d = 1'b0;
      dat_low_d = 1'b0;
      done_d    = 1'b1;
      error_d   = 1'b1;
    end
    // The done cycle still counts as busy so a new request lands one cycle later.
    ready_d = (state_d == IDLE) && !done_d;
    busy_d  = !ready_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      nack_q    <= 1'b0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      nack_q    <= nack_d;
      clk_low_q <= clk_low_d;
      dat_low_q <= dat_low_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign clock_drive_low = clk_low_q;
  assign data_drive_low  = dat_low_q;
  assign tx.tx_ready     = ready_q;
  assign tx.busy         = busy_q;
  assign tx.tx_done      = done_q;
  assign tx.tx_error     = error_q;
endmodule

// File: tb/tb_kfps2kb_host_tx.sv
// tb/tb_kfps2kb_host_tx.sv - self-checking bench for kfps2kb_host_tx with a PS/2 device model
module tb_kfps2kb_host_tx;
  localparam int INH    = 4;
  localparam int REQ    = 20;
  localparam int OVR    = 12;
  localparam int FE_LAT = 3;  // pin fall to the clock edge where the host acts on it

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic device_clock, device_data, clock_drive_low, data_drive_low;
  int   checks = 0;
  int   errors = 0;

  logic [9:0] o_bits;
  int   o_inh, o_req_idx, o_done_idx, o_fall_idx, o_done_cnt;
  bit   o_done, o_restart;
  logic o_err, o_cdl_done, o_ddl_done, o_ddl_before, o_ready_at_done, o_ready_after, o_start_pin;
  logic o_rst_cdl, o_rst_ddl, o_rst_done, o_rst_ready, o_rst_pre_ddl;

  kfps2kb_host_tx_if tx ();

  assign device_clock = dev_clk & ~clock_drive_low;
  assign device_data  = dev_dat & ~data_drive_low;

  kfps2kb_host_tx #(
    .inhibit_time(24'(INH)), .request_time(24'(REQ)), .over_time(24'(OVR))
  ) dut (
    .clock(clock), .reset(reset), .device_clock(device_clock), .device_data(device_data),
    .clock_drive_low(clock_drive_low), .data_drive_low(data_drive_low), .tx(tx)
  );

  always #5 clock = ~clock;

  function automatic logic [9:0] exp_frame(input logic [7:0] d);
    logic [9:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = d[i];
      ones += int'(d[i]);
    end
    f[8] = (ones % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // Device: first fall 4 cycles after the host releases the clock, then low 3 / high 3.
  task automatic send_frame(input logic [7:0] d, input bit nack, input int nfalls,
                            input int rst_fall, input bit hold_valid, input logic [7:0] d_after);
    int k, falls, rises, next_fall;
    bit finished, prev_cdl, prev_ddl;
    o_bits = 10'bx; o_inh = 0; o_req_idx = -1; o_done_idx = -1; o_fall_idx = -1; o_done_cnt = 0;
    o_done = 0; o_restart = 0; o_err = 1'bx; o_cdl_done = 1'bx; o_ddl_done = 1'bx;
    o_ddl_before = 1'bx; o_ready_at_done = 1'bx; o_ready_after = 1'bx; o_start_pin = 1'bx;
    o_rst_cdl = 1'bx; o_rst_ddl = 1'bx; o_rst_done = 1'bx; o_rst_ready = 1'bx; o_rst_pre_ddl = 1'bx;
    k = 0; falls = 0; rises = 0; next_fall = -1; finished = 0; prev_cdl = 0; prev_ddl = 0;
    @(negedge clock);
    tx.tx_valid = 1'b1;
    tx.tx_data  = d;
    while (!finished && k < 3000) begin
      @(negedge clock);
      k++;
      if (k == 1) begin
        tx.tx_valid = hold_valid;
        tx.tx_data  = d_after;
      end
      if (clock_drive_low) begin
        if (o_done) o_restart = 1'b1;
        else o_inh++;
      end
      if (prev_cdl && !clock_drive_low && o_req_idx < 0) begin
        o_req_idx = k;
        if (nfalls > 0) next_fall = k + 4;
      end
      if (tx.tx_done === 1'b1) begin
        o_done_cnt++;
        if (!o_done) begin
          o_done = 1; o_done_idx = k; o_err = tx.tx_error;
          o_cdl_done = clock_drive_low; o_ddl_done = data_drive_low;
          o_ddl_before = prev_ddl; o_ready_at_done = tx.tx_ready;
          tx.tx_valid = 1'b0;
        end
      end
      if (o_done && k == o_done_idx + 1) o_ready_after = tx.tx_ready;
      if (o_done && k >= o_done_idx + 4) finished = 1'b1;
      prev_cdl = clock_drive_low;
      prev_ddl = data_drive_low;
      if (next_fall >= 0 && k == next_fall) begin
        falls++;
        o_fall_idx = k;
        if (falls == 1) o_start_pin = device_data;
        dev_clk = 1'b0;
        if (falls == rst_fall) begin
          o_rst_pre_ddl = data_drive_low;
          reset = 1'b1;
          @(negedge clock);
          o_rst_cdl = clock_drive_low; o_rst_ddl = data_drive_low; o_rst_done = tx.tx_done;
          reset = 1'b0; dev_clk = 1'b1; dev_dat = 1'b1;
          @(negedge clock);
          o_rst_ready = tx.tx_ready;
          finished = 1'b1;
        end
      end else if (next_fall >= 0 && k == next_fall + 3) begin
        rises++;
        dev_clk = 1'b1;
        if (rises <= 10) o_bits[rises-1] = device_data;
        if (rises == 10) dev_dat = nack;
        if (rises == 11) dev_dat = 1'b1;
        next_fall = (falls < nfalls) ? next_fall + 6 : -1;
      end
    end
    tx.tx_valid = 1'b0;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if ({tx.tx_ready, tx.busy} !== 2'b10) begin errors++; $display("FAIL reset_ready_busy: got %b required 10", {tx.tx_ready, tx.busy}); end
    checks++; if ({tx.tx_done, tx.tx_error} !== 2'b00) begin errors++; $display("FAIL reset_done_err: got %b required 00", {tx.tx_done, tx.tx_error}); end
    checks++; if ({clock_drive_low, data_drive_low} !== 2'b00) begin errors++; $display("FAIL reset_lines: got %b required 00", {clock_drive_low, data_drive_low}); end
    reset = 1'b0;
    @(negedge clock);
    checks++; if (tx.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", tx.tx_ready); end
  endtask

  task automatic test_led_cmd();
    send_frame(8'hED, 0, 11, 0, 0, 8'hED);
    checks++; if (o_bits !== 10'b11_1110_1101) begin errors++; $display("FAIL led_bits: got %b required %b", o_bits, 10'b11_1110_1101); end
    checks++; if (o_done !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL led_done: done %b err %b required 1 0", o_done, o_err); end
    checks++; if (o_inh !== INH) begin errors++; $display("FAIL led_inhibit_len: got %0d required %0d", o_inh, INH); end
    checks++; if (o_start_pin !== 1'b0) begin errors++; $display("FAIL led_start_bit: got %b required 0", o_start_pin); end
    checks++; if (o_ready_at_done !== 1'b0 || o_ready_after !== 1'b1) begin errors++; $display("FAIL led_ready: at done %b after %b required 0 1", o_ready_at_done, o_ready_after); end
    checks++; if (o_done_cnt !== 1) begin errors++; $display("FAIL led_done_count: got %0d required 1", o_done_cnt); end
  endtask

  task automatic test_parity();
    send_frame(8'hFF, 0, 11, 0, 0, 8'hFF);
    checks++; if (o_bits[8] !== 1'b1 || o_err !== 1'b0) begin errors++; $display("FAIL parity_ff: par %b err %b required 1 0", o_bits[8], o_err); end
    checks++; if (o_bits !== exp_frame(8'hFF)) begin errors++; $display("FAIL frame_ff: got %b required %b", o_bits, exp_frame(8'hFF)); end
    send_frame(8'h01, 0, 11, 0, 0, 8'h01);
    checks++; if (o_bits[8] !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL parity_01: par %b err %b required 0 0", o_bits[8], o_err); end
    checks++; if (o_bits !== exp_frame(8'h01)) begin errors++; $display("FAIL frame_01: got %b required %b", o_bits, exp_frame(8'h01)); end
  endtask

  task automatic test_nack();
    send_frame(8'hF3, 1, 11, 0, 0, 8'hF3);
    checks++; if (o_done !== 1'b1 || o_err !== 1'b1) begin errors++; $display("FAIL nack_done_err: done %b err %b required 1 1", o_done, o_err); end
    checks++; if ({o_cdl_done, o_ddl_done} !== 2'b00) begin errors++; $display("FAIL nack_lines: got %b required 00", {o_cdl_done, o_ddl_done}); end
    checks++; if (o_ready_after !== 1'b1) begin errors++; $display("FAIL nack_ready_after: got %b required 1", o_ready_after); end
  endtask

  task automatic test_request_timeout();
    send_frame(8'hED, 0, 0, 0, 0, 8'hED);
    checks++; if (o_done !== 1'b1 || o_done_idx - o_req_idx !== REQ) begin errors++; $display("FAIL req_timeout_time: done %b after %0d cycles required %0d", o_done, o_done_idx - o_req_idx, REQ); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL req_timeout_err: got %b required 1", o_err); end
    checks++; if ({o_ddl_before, o_ddl_done} !== 2'b10) begin errors++; $display("FAIL req_timeout_data: got %b required 10", {o_ddl_before, o_ddl_done}); end
  endtask

  task automatic test_stall_timeout();
    send_frame(8'hA6, 0, 4, 0, 1, 8'h5B);
    checks++; if (o_done !== 1'b1 || o_done_idx - o_fall_idx !== FE_LAT + OVR) begin errors++; $display("FAIL stall_time: done %b after %0d cycles required %0d", o_done, o_done_idx - o_fall_idx, FE_LAT + OVR); end
    checks++; if (o_err !== 1'b1 || {o_cdl_done, o_ddl_done} !== 2'b00) begin errors++; $display("FAIL stall_err_lines: err %b lines %b required 1 00", o_err, {o_cdl_done, o_ddl_done}); end
    checks++; if (o_bits[3:0] !== 4'h6) begin errors++; $display("FAIL stall_bits: got %b required 0110", o_bits[3:0]); end
    checks++; if (o_done_cnt !== 1 || o_restart) begin errors++; $display("FAIL stall_single_attempt: dones %0d restart %b required 1 0", o_done_cnt, o_restart); end
  endtask

  task automatic test_reset_mid();
    send_frame(8'hED, 0, 11, 6, 0, 8'hED);
    checks++; if (o_rst_pre_ddl !== 1'b1) begin errors++; $display("FAIL midrst_active: data_drive_low %b required 1", o_rst_pre_ddl); end
    checks++; if ({o_rst_cdl, o_rst_ddl, o_rst_done} !== 3'b000) begin errors++; $display("FAIL midrst_release: got %b required 000", {o_rst_cdl, o_rst_ddl, o_rst_done}); end
    checks++; if (o_rst_ready !== 1'b1 || o_done) begin errors++; $display("FAIL midrst_ready: ready %b done %b required 1 0", o_rst_ready, o_done); end
    send_frame(8'hF4, 0, 11, 0, 0, 8'hF4);
    checks++; if (o_bits !== exp_frame(8'hF4) || o_err !== 1'b0 || !o_done) begin errors++; $display("FAIL midrst_resend: bits %b err %b required %b 0", o_bits, o_err, exp_frame(8'hF4)); end
  endtask

  task automatic test_random();
    logic [7:0] d, da;
    bit nk, hv;
    for (int i = 0; i < 6; i++) begin
      d  = 8'($urandom_range(0, 255));
      da = 8'($urandom_range(0, 255));
      nk = 1'($urandom_range(0, 1));
      hv = 1'($urandom_range(0, 1));
      send_frame(d, nk, 11, 0, hv, da);
      checks++; if (o_bits !== exp_frame(d)) begin errors++; $display("FAIL rand_bits[%0d]: data %h got %b required %b", i, d, o_bits, exp_frame(d)); end
      checks++; if (o_done !== 1'b1 || o_err !== 1'(nk) || o_done_cnt !== 1 || o_restart) begin errors++; $display("FAIL rand_result[%0d]: done %b err %b dones %0d required 1 %b 1", i, o_done, o_err, o_done_cnt, nk); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    test_reset();
    test_led_cmd();
    test_parity();
    test_nack();
    test_request_timeout();
    test_stall_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
